// File: rtl/comparador_serial.sv
// comparador_serial
//   Serial magnitude comparator. One iterative-comparison cell is reused over
//   WIDTH clock cycles. It walks both operands from LSB to MSB. The cell state
//   is kept in a single register, so the most significant differing bit is the
//   last one to write it.
//
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset (overrides start and any run)
//   start       request, accepted only while busy=0
//   A, B        operands, captured on the accepted start edge only
//   busy        comparison in progress
//   done        one-cycle pulse, result just became valid
//   menorIgual  result A<=B, held until the next completion
//   mayor       result A>B, held until the next completion
//
// State table
//   state | meaning
//   IDLE  | waiting for start; results hold their last values
//   RUN   | one cell evaluation per clock, LSB first; the last bit finishes the run

module comparador_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             menorIgual,
  output logic             mayor
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  // Cell state encoding: a = "A<=B so far", b = "A>B so far".
  localparam logic CELL_A = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_a_q, sh_a_d;
  logic [WIDTH-1:0] sh_b_q, sh_b_d;
  logic             p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             menor_q, menor_d;
  logic             mayor_q, mayor_d;
  logic             p_next;

  // A differing bit pair overrides everything seen at lower significance:
  // Bi=1 means A<B at this bit, and Bi=0 means A>B. Equal bits keep the state.
  assign p_next = (sh_a_q[0] != sh_b_q[0]) ? sh_b_q[0] : p_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sh_a_q  <= '0;
      sh_b_q  <= '0;
      p_q     <= CELL_A;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      menor_q <= 1'b0;
      mayor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_a_q  <= sh_a_d;
      sh_b_q  <= sh_b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      menor_q <= menor_d;
      mayor_q <= mayor_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sh_a_d  = sh_a_q;
    sh_b_d  = sh_b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    menor_d = menor_q;
    mayor_d = mayor_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          sh_a_d  = A;
          sh_b_d  = B;
          p_d     = CELL_A;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        p_d    = p_next;
        sh_a_d = sh_a_q >> 1;
        sh_b_d = sh_b_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          menor_d = p_next;
          mayor_d = ~p_next;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == RUN);
  assign done       = done_q;
  assign menorIgual = menor_q;
  assign mayor      = mayor_q;

endmodule
